// File: rtl/text_pixel_renderer_if.sv
// Video-side bundle for text_pixel_renderer: timing-generator coordinates and
// syncs going in, pixel colour and realigned syncs coming out.
// There is no valid/ready pair. Every clk one coordinate sample is taken and
// one pixel is produced three clocks later. The source cannot stall the
// renderer and the sink cannot apply back-pressure.
interface text_pixel_renderer_if #(
    parameter int COLOR_W = 8
);
    logic [9:0]         hcount;
    logic [9:0]         vcount;
    logic               de_in;
    logic               hsync_in;
    logic               vsync_in;
    logic [COLOR_W-1:0] rgb;
    logic               hsync_out;
    logic               vsync_out;
    logic               de_out;

    // The timing generator and pixel sink side.
    modport master (
        output hcount, vcount, de_in, hsync_in, vsync_in,
        input  rgb, hsync_out, vsync_out, de_out
    );

    // The renderer side.
    modport slave (
        input  hcount, vcount, de_in, hsync_in, vsync_in,
        output rgb, hsync_out, vsync_out, de_out
    );
endinterface

// File: rtl/text_pixel_renderer.sv
// text_pixel_renderer: turns VGA pixel coordinates into a text-mode pixel
// stream. It uses a character buffer and a font ROM, and both are 1-cycle
// registered reads. Every path from input to output has a latency of 3 clk.
// Optional feature: define FONT_CURSOR_EN to get a blinking underline cursor
// at (cursor_col, cursor_row). The default build has no cursor logic.
module text_pixel_renderer #(
    parameter int                 FONT_W       = 4,
    parameter int                 FONT_H_LOG2  = 3,
    parameter int                 CHAR_BITS    = 7,
    parameter int                 COLS         = 160,
    parameter int                 ROWS         = 60,
    parameter int                 TEXT_AW      = 14,
    parameter int                 COLOR_W      = 8,
    parameter logic [COLOR_W-1:0] FG_COLOR     = 8'hFF,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 8'h00,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic                             clk,
    input  logic                             rst,
    text_pixel_renderer_if.slave             vid,
    output logic [TEXT_AW-1:0]               char_addr,
    input  logic [CHAR_BITS-1:0]             char_data,
    output logic [CHAR_BITS+FONT_H_LOG2-1:0] font_addr,
    input  logic [FONT_W-1:0]                font_rdata,
    input  logic [7:0]                       cursor_col,
    input  logic [5:0]                       cursor_row
);
    localparam int PCOL_W = (FONT_W > 1) ? $clog2(FONT_W) : 1;

    // Stage 0: locate the text cell that covers the current pixel.
    logic [9:0] col0;
    logic [9:0] row0;
    logic       in_range0;
    logic       cur0;

    assign col0      = 10'(vid.hcount / FONT_W);
    assign row0      = vid.vcount >> FONT_H_LOG2;
    assign char_addr = TEXT_AW'(row0 * COLS + col0);
    // Cells off the text grid only appear during blanking. Masking de here
    // guarantees that they are never drawn.
    assign in_range0 = (int'(col0) < COLS) && (int'(row0) < ROWS);

`ifdef FONT_CURSOR_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;
    logic               vs_d;

    // Count frames on vsync_in rising edges and flip the blink phase on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            vs_d         <= 1'b0;
        end else begin
            vs_d <= vid.vsync_in;
            if (vid.vsync_in && !vs_d) begin
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // The underline cursor occupies the bottom glyph row of the cursor cell.
    assign cur0 = !blink_hidden
                  && (col0 == 10'(cursor_col))
                  && (row0 == 10'(cursor_row))
                  && (&vid.vcount[FONT_H_LOG2-1:0]);
`else
    logic unused_cursor;
    assign unused_cursor = &{1'b0, cursor_col, cursor_row};
    assign cur0          = 1'b0;
`endif

    // Stage 1: char_data arrives. Keep the glyph row, pixel column and syncs.
    logic [FONT_H_LOG2-1:0] s1_grow;
    logic [PCOL_W-1:0]      s1_pcol;
    logic                   s1_de, s1_hs, s1_vs, s1_cur;

    // Stage-1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_grow <= '0;
            s1_pcol <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_cur  <= 1'b0;
        end else begin
            s1_grow <= vid.vcount[FONT_H_LOG2-1:0];
            s1_pcol <= PCOL_W'(vid.hcount % FONT_W);
            s1_de   <= vid.de_in & in_range0;
            s1_hs   <= vid.hsync_in;
            s1_vs   <= vid.vsync_in;
            s1_cur  <= cur0 & in_range0;
        end
    end

    assign font_addr = {char_data, s1_grow};

    // Stage 2: font_rdata arrives. Keep the column and syncs lined up with it.
    logic [PCOL_W-1:0] s2_pcol;
    logic              s2_de, s2_hs, s2_vs, s2_cur;

    // Stage-2 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_pcol <= '0;
            s2_de   <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
            s2_cur  <= 1'b0;
        end else begin
            s2_pcol <= s1_pcol;
            s2_de   <= s1_de;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_cur  <= s1_cur;
        end
    end

    // The leftmost pixel is the glyph MSB. Shift the selected bit up to the
    // top instead of indexing with a computed position.
    logic [FONT_W-1:0] row_shift;
    logic              pix_on;

    assign row_shift = font_rdata << s2_pcol;
    assign pix_on    = row_shift[FONT_W-1] | s2_cur;

    // Stage 3: register the colour and the syncs together. Blanked pixels are 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid.rgb       <= '0;
            vid.hsync_out <= 1'b0;
            vid.vsync_out <= 1'b0;
            vid.de_out    <= 1'b0;
        end else begin
            vid.rgb       <= s2_de ? (pix_on ? FG_COLOR : BG_COLOR) : '0;
            vid.hsync_out <= s2_hs;
            vid.vsync_out <= s2_vs;
            vid.de_out    <= s2_de;
        end
    end
endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer. It models the character buffer and font ROM
// as 1-cycle registered reads. Directed pixel vectors push expected outputs,
// tagged with the cycle in which they are due. An independent monitor pops
// each entry on that cycle and compares it with the DUT outputs.
module tb_text_pixel_renderer;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] cyc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  text_pixel_renderer_if #(.COLOR_W(8)) vid ();

  logic [13:0] char_addr;
  logic [6:0]  char_data;
  logic [9:0]  font_addr;
  logic [3:0]  font_rdata;
  logic [7:0]  cursor_col;
  logic [5:0]  cursor_row;

  text_pixel_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .vid        (vid.slave),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .font_addr  (font_addr),
    .font_rdata (font_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  // Buffer and ROM models, both registered reads.
  logic [6:0] buf_mem [0:16383];
  logic [3:0] rom     [0:1023];

  always @(posedge clk) begin
    char_data  <= buf_mem[char_addr];
    font_rdata <= rom[font_addr];
  end

  // Scoreboard: {due_cycle[31:0], rgb[7:0], hsync, vsync, de}
  logic [42:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare the DUT outputs with any entry due on this cycle.
  always @(negedge clk) begin : monitor
    logic [42:0] e;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0][42:11] < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_entry due %0d seen at cycle %0d", e[42:11], cyc);
      end
      if (exp_q.size() > 0 && exp_q[0][42:11] == cyc) begin
        e = exp_q.pop_front();
        check("rgb",       32'(vid.rgb),       32'(e[10:3]));
        check("hsync_out", 32'(vid.hsync_out), 32'(e[2]));
        check("vsync_out", 32'(vid.vsync_out), 32'(e[1]));
        check("de_out",    32'(vid.de_out),    32'(e[0]));
      end
    end
  end

  // Driver: apply one pixel sample and queue its expected output 3 clk later.
  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input logic hs, input logic vs, input logic [7:0] exp_rgb);
    @(negedge clk);
    vid.hcount   = h;
    vid.vcount   = v;
    vid.de_in    = de;
    vid.hsync_in = hs;
    vid.vsync_in = vs;
    exp_q.push_back({cyc + 32'd3, exp_rgb, hs, vs, de});
  endtask

  // Release reset with pixel (0,0) already applied. The two cycles before it
  // must still show zero outputs.
  task automatic release_with_pixel();
    @(negedge clk);
    rst          = 1'b0;
    vid.hcount   = 10'd0;
    vid.vcount   = 10'd0;
    vid.de_in    = 1'b1;
    vid.hsync_in = 1'b0;
    vid.vsync_in = 1'b0;
    exp_q.push_back({cyc + 32'd1, 8'h00, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({cyc + 32'd2, 8'h00, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({cyc + 32'd3, 8'hFF, 1'b0, 1'b0, 1'b1});
  endtask

  // Assert reset mid-stream with hsync high. Outputs must be zero after the next edge.
  task automatic apply_reset(input int hold);
    @(negedge clk);
    rst          = 1'b1;
    vid.hsync_in = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_rgb",   32'(vid.rgb),       32'd0);
    check("rst_hsync", 32'(vid.hsync_out), 32'd0);
    check("rst_vsync", 32'(vid.vsync_out), 32'd0);
    check("rst_de",    32'(vid.de_out),    32'd0);
    repeat (hold) @(negedge clk);
    release_with_pixel();
  endtask

  initial begin
    logic [7:0] exp_cur;

    for (int i = 0; i < 16384; i++) buf_mem[i] = 7'h41;
    for (int i = 0; i < 1024; i++) rom[i] = 4'b0000;
    buf_mem[322]          = 7'h42;
    rom[{7'h41, 3'd0}]    = 4'b1010;
    rom[{7'h42, 3'd1}]    = 4'b1100;

    cursor_col   = 8'd5;
    cursor_row   = 6'd2;
    rst          = 1'b1;
    vid.hcount   = '0;
    vid.vcount   = '0;
    vid.de_in    = 1'b0;
    vid.hsync_in = 1'b0;
    vid.vsync_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("init_rgb",   32'(vid.rgb),       32'd0);
    check("init_hsync", 32'(vid.hsync_out), 32'd0);
    check("init_vsync", 32'(vid.vsync_out), 32'd0);
    check("init_de",    32'(vid.de_out),    32'd0);
    release_with_pixel();

    // Glyph 0x41 row 0 = 1010 across hcount 0..3
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(10'd3, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    // A set glyph bit with de low must stay black
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Cell (2,2): address 322 holds 0x42, row 1 = 1100
    drive(10'd8, 10'd17, 1'b1, 1'b0, 1'b0, 8'hFF);
    #1;
    check("char_addr_322", 32'(char_addr), 32'd322);
    @(posedge clk);
    #1;
    check("font_addr", 32'(font_addr), 32'({7'h42, 3'd1}));
    drive(10'd9,  10'd17, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(10'd10, 10'd17, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(10'd11, 10'd17, 1'b1, 1'b0, 1'b0, 8'h00);

    // Last visible pixel: row 59, col 159
    drive(10'd639, 10'd479, 1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    check("char_addr_last", 32'(char_addr), 32'd9599);

    // Blanking with a 3-cycle hsync pulse
    for (int i = 0; i < 10; i++)
      drive(10'(i), 10'd0, 1'b0, (i >= 3 && i < 6), 1'b0, 8'h00);

    // Vsync pulse passes through
    for (int i = 0; i < 6; i++)
      drive(10'd0, 10'd490, 1'b0, 1'b0, (i >= 1 && i < 4), 8'h00);

    // Mid-line reset discards in-flight pixels and clears the blink counter
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 8'hFF);
    apply_reset(2);
    drive(10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 8'hFF);

    // Cursor cell (5,2), bottom glyph row blank, sampled across blink phases
    for (int f = 0; f <= 60; f++) begin
      if (f == 0 || f == 29 || f == 30 || f == 59 || f == 60) begin
`ifdef FONT_CURSOR_EN
        exp_cur = ((f / 30) % 2 == 0) ? 8'hFF : 8'h00;
`else
        exp_cur = 8'h00;
`endif
        for (int x = 20; x < 24; x++)
          drive(10'(x), 10'd23, 1'b1, 1'b0, 1'b0, exp_cur);
      end
      drive(10'd0, 10'd490, 1'b0, 1'b0, 1'b1, 8'h00);
      drive(10'd0, 10'd490, 1'b0, 1'b0, 1'b0, 8'h00);
    end

    // Drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
